ofm_write_controller: RTL
=========================

Name: ofm_write_controller

Overview:
- Write-back counterpart of the per-PE IFM read-address controller: collects one result per PE from the 16-PE array and serialises the results into single-port OFM buffer writes.
- Generates OFM write addresses from per-lane tile offsets plus a column/row/channel base, and emits change_row / change_channel / end_OFM progress pulses.
- Sits between the PE array outputs and the OFM SRAM.

Parameters:
- N_PE, 16, number of PE result lanes.
- DATA_W, 16, result width per lane.
- ADDR_W, 13, OFM buffer address width.
- TILE_W, 4, output tile width. Tile height is N_PE/TILE_W = 4.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; rising level starts a layer, low aborts.
- cfg_width  input  9  OFM width in pixels (multiple of TILE_W, at least TILE_W).
- cfg_height  input  9  OFM height in pixels (multiple of 4, at least 4).
- cfg_channels  input  9  number of OFM channels (at least 1).
- pe_valid  input  N_PE  per-lane result valid.
- pe_data  input  N_PE*DATA_W  packed lane results; lane i occupies [i*DATA_W +: DATA_W].
- pe_ready  output  N_PE  per-lane accept.
- wr_en  output  1  OFM write strobe.
- wr_addr  output  ADDR_W  OFM write address.
- wr_data  output  DATA_W  OFM write data.
- change_row  output  1  one-cycle pulse when the tile row advances.
- change_channel  output  1  one-cycle pulse when the channel advances.
- end_OFM  output  1  one-cycle pulse on the last write of the layer.
- busy  output  1  high while in RUN.

Behaviour:
- Reset: all outputs 0. State IDLE. held, done and pointer cleared. Counters cleared.
- FSM states:
  - IDLE → RUN when en=1. On this transition cfg_* is latched and col=row=ch=0, base=0.
  - RUN → DONE on the cycle end_OFM is asserted.
  - DONE → IDLE when en=0.
  - RUN → IDLE immediately if en=0 (abort). Abort drops held data and clears done; wr_en is 0 from the next cycle. Pulses are never generated by an abort.
- Per-lane registers:
  - held[i]: a one-deep data buffer.
  - done[i]: set when lane i has been written in the current batch.
  - pe_ready[i] = (state==RUN) & ~held[i] & ~done[i]. This is combinational.
  - A lane is captured when pe_valid[i] & pe_ready[i] at a clock edge.
- Arbiter:
  - Round-robin among held lanes, searching from the pointer upward with modulo N_PE wrap.
  - At most one grant per cycle.
  - On a grant of lane k: held[k]←0, done[k]←1, pointer←(k+1) mod N_PE.
- Write timing:
  - wr_en, wr_addr and wr_data are registered.
  - Data captured at edge t appears on wr_* at the earliest after edge t+1 (latency 1 when there is no contention).
- Address:
  - wr_addr = base + (k/TILE_W)*cfg_width + (k%TILE_W), computed modulo 2^ADDR_W.
  - base = ch*cfg_width*cfg_height + row*cfg_width + col. base is maintained incrementally; no runtime multiplier on the base path.
- Batch completion (the grant that makes done all-ones):
  - done clears at the same edge.
  - If col+TILE_W < cfg_width: col += TILE_W.
  - Otherwise col=0 and change_row pulses. Then:
    - if row+4 < cfg_height: row += 4;
    - otherwise row=0, change_channel pulses, and ch += 1;
    - if ch was cfg_channels-1: end_OFM pulses instead of advancing.
  - Pulses are registered and coincide with the wr_en of the completing write.
- A lane may not deliver its next-batch result until the current batch completes (pe_ready low). A lane captured on the completion edge is illegal because its ready was low.
- Simultaneous events:
  - Capture and grant in the same cycle, on different lanes, are both performed.
  - The same lane cannot be captured and granted in the same cycle.
- Out-of-range cfg values (0 or non-multiple) give undefined addresses but must not hang the FSM beyond an en deassert.

Test Plan:
- Single batch: cfg 8/8/1, all 16 pe_valid in one cycle → 16 consecutive writes starting 1 cycle later, lanes 0..15. Addresses 0,1,2,3,8,9,10,11,16,17,18,19,24,25,26,27. No pulses.
- Full layer: cfg 8/8/1, four batches → second batch base 4 and change_row with its 16th write. Third batch base 32. Last write at addr 63 carries end_OFM and change_row and change_channel. busy then drops and the FSM holds DONE until en=0.
- Multi-channel: cfg 4/4/2 → batch 1 ends with change_row and change_channel. Batch 2 addresses 16..31. end_OFM on the write to 31.
- Round-robin: pointer=3, lanes 2 and 5 held → lane 5 written first, then lane 2. Pointer ends at 3.
- Backpressure: lane 3 written and pe_valid[3] held high → pe_ready[3]=0 until the batch-completion edge, then 1. The next value of lane 3 lands at the new base+3.
- Abort/reset: en dropped after 7 writes → wr_en=0 next cycle, pe_ready=0, no pulses. Re-enable restarts at addr 0. Asserting reset_n low mid-write clears all outputs asynchronously.

Source files
------------

// File: rtl/ofm_write_controller.sv
// Serialises one result per PE lane into OFM buffer writes; write appears 1 cycle after capture when uncontended.
// Backpressure: a lane is not ready while it holds data or was already written this batch.
module ofm_write_controller #(
  parameter int N_PE   = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int TILE_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [8:0]               cfg_width,
  input  logic [8:0]               cfg_height,
  input  logic [8:0]               cfg_channels,
  input  logic [N_PE-1:0]          pe_valid,
  input  logic [N_PE*DATA_W-1:0]   pe_data,
  output logic [N_PE-1:0]          pe_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     change_row,
  output logic                     change_channel,
  output logic                     end_OFM,
  output logic                     busy
);

  localparam int TILE_H = N_PE / TILE_W;
  localparam int PTR_W  = $clog2(N_PE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [8:0]          w_q, h_q, c_q;
  logic [8:0]          col_q, row_q, ch_q;
  logic [ADDR_W-1:0]   line_base, base;
  logic [N_PE-1:0]     held, done;
  logic [DATA_W-1:0]   lane_dat [N_PE];
  logic [PTR_W-1:0]    ptr;

  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic                run_act, grant, batch_done;
  logic                col_wrap, row_wrap, last_ch, layer_end;
  logic [N_PE-1:0]     gnt_mask, cap_mask;
  logic [ADDR_W-1:0]   lane_off, row_step;
  logic [9:0]          col_sum, row_sum;

  assign busy     = (state == RUN);
  assign pe_ready = {N_PE{state == RUN}} & ~held & ~done;
  assign run_act  = (state == RUN) && en;

  // Round-robin: first held lane at or above the pointer, wrapping modulo N_PE.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < N_PE; j++) begin
      if (!gnt_vld && held[(int'(ptr) + j) % N_PE]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'((int'(ptr) + j) % N_PE);
      end
    end
  end

  assign grant      = run_act && gnt_vld;
  assign gnt_mask   = grant ? (N_PE'(1) << gnt_idx) : '0;
  assign cap_mask   = run_act ? (pe_valid & pe_ready) : '0;
  assign batch_done = grant && (&(done | gnt_mask));

  assign col_sum   = {1'b0, col_q} + 10'(TILE_W);
  assign row_sum   = {1'b0, row_q} + 10'(TILE_H);
  assign col_wrap  = (col_sum >= {1'b0, w_q});
  assign row_wrap  = (row_sum >= {1'b0, h_q});
  assign last_ch   = (ch_q == c_q - 9'd1);
  assign layer_end = batch_done && col_wrap && row_wrap && last_ch;

  // Lane offset within the tile; the multiplier only sees a tiny tile-row index.
  assign lane_off = ADDR_W'(w_q) * ADDR_W'(gnt_idx / PTR_W'(TILE_W))
                  + ADDR_W'(gnt_idx % PTR_W'(TILE_W));
  assign row_step = ADDR_W'(w_q) * ADDR_W'(TILE_H);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
               else if (layer_end) state_nxt = DONE;
      DONE:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q            <= '0;
      h_q            <= '0;
      c_q            <= '0;
      col_q          <= '0;
      row_q          <= '0;
      ch_q           <= '0;
      line_base      <= '0;
      base           <= '0;
      held           <= '0;
      done           <= '0;
      ptr            <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      change_row     <= 1'b0;
      change_channel <= 1'b0;
      end_OFM        <= 1'b0;
      for (int i = 0; i < N_PE; i++) lane_dat[i] <= '0;
    end else begin
      wr_en          <= 1'b0;
      change_row     <= 1'b0;
      change_channel <= 1'b0;
      end_OFM        <= 1'b0;
      if (state == IDLE && en) begin
        w_q       <= cfg_width;
        h_q       <= cfg_height;
        c_q       <= cfg_channels;
        col_q     <= '0;
        row_q     <= '0;
        ch_q      <= '0;
        line_base <= '0;
        base      <= '0;
      end else if (state == RUN && !en) begin
        held <= '0;
        done <= '0;
      end else if (run_act) begin
        held <= (held | cap_mask) & ~gnt_mask;
        for (int i = 0; i < N_PE; i++)
          if (cap_mask[i]) lane_dat[i] <= pe_data[i*DATA_W +: DATA_W];
        if (grant) begin
          wr_en   <= 1'b1;
          wr_addr <= base + lane_off;
          wr_data <= lane_dat[gnt_idx];
          ptr     <= PTR_W'((int'(gnt_idx) + 1) % N_PE);
          done    <= batch_done ? '0 : (done | gnt_mask);
        end
        if (batch_done) begin
          if (!col_wrap) begin
            col_q <= col_sum[8:0];
            base  <= base + ADDR_W'(TILE_W);
          end else begin
            // Row and channel wraps both step the line base by one tile height of rows.
            col_q      <= '0;
            change_row <= 1'b1;
            line_base  <= line_base + row_step;
            base       <= line_base + row_step;
            if (!row_wrap) begin
              row_q <= row_sum[8:0];
            end else begin
              row_q          <= '0;
              change_channel <= 1'b1;
              if (last_ch) end_OFM <= 1'b1;
              else         ch_q    <= ch_q + 9'd1;
            end
          end
        end
      end
    end
  end

endmodule
